// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: steps the live PWM duty toward an accepted target on prescaler ticks.
// Optional target clamp to DUTY_MAX (with clamp_hit flag) is enabled by defining DUTY_CLAMP_EN.
module pwm_ramp_ctrl #(
   parameter int DUTY_W = 8,
   parameter int STEP_W = 4
`ifdef DUTY_CLAMP_EN
   ,
   parameter int DUTY_MAX = 200
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              tgt_valid,
   output logic              tgt_ready,
   input  logic [DUTY_W-1:0] tgt_duty,
   input  logic [STEP_W-1:0] step,
   input  logic              abort,
   output logic [DUTY_W-1:0] duty,
   output logic              pwm_load,
   output logic              busy,
   output logic              done
`ifdef DUTY_CLAMP_EN
   ,
   output logic              clamp_hit
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t            state_r;
   logic [DUTY_W-1:0] duty_r;
   logic [DUTY_W-1:0] tgt_r;
   logic [STEP_W-1:0] step_r;
   logic              pwm_load_r;
   logic              busy_r;
   logic              done_r;
   logic              tgt_ready_r;

   logic [DUTY_W:0]   sum_s;
   logic [DUTY_W-1:0] diff_s;
   logic [DUTY_W-1:0] step_dw_s;
   logic [DUTY_W-1:0] up_next_s;
   logic [DUTY_W-1:0] down_next_s;
   logic [DUTY_W-1:0] tgt_in_s;
   logic [STEP_W-1:0] step_in_s;

`ifdef DUTY_CLAMP_EN
   localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_MAX[DUTY_W-1:0];
   logic clamp_s;
   logic clamp_hit_r;
`endif

   // Target and step as they would be latched on accept (zero step promoted to one).
   always_comb begin
      step_in_s = step;
      if (step == {STEP_W{1'b0}}) begin
         step_in_s = {{(STEP_W-1){1'b0}}, 1'b1};
      end else begin
         step_in_s = step;
      end
`ifdef DUTY_CLAMP_EN
      clamp_s  = 1'b0;
      tgt_in_s = tgt_duty;
      if (tgt_duty > DUTY_MAX_V) begin
         clamp_s  = 1'b1;
         tgt_in_s = DUTY_MAX_V;
      end else begin
         clamp_s  = 1'b0;
         tgt_in_s = tgt_duty;
      end
`else
      tgt_in_s = tgt_duty;
`endif
   end

   // Next duty for one up/down step; the up-sum carries an extra bit and the
   // down path compares the remaining distance first, so neither can wrap.
   always_comb begin
      step_dw_s   = DUTY_W'(step_r);
      sum_s       = (DUTY_W+1)'(duty_r) + (DUTY_W+1)'(step_r);
      diff_s      = duty_r - tgt_r;
      up_next_s   = tgt_r;
      down_next_s = tgt_r;
      if (sum_s >= {1'b0, tgt_r}) begin
         up_next_s = tgt_r;
      end else begin
         up_next_s = sum_s[DUTY_W-1:0];
      end
      if (diff_s <= step_dw_s) begin
         down_next_s = tgt_r;
      end else begin
         down_next_s = duty_r - step_dw_s;
      end
   end

   // Ramp FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         duty_r      <= {DUTY_W{1'b0}};
         tgt_r       <= {DUTY_W{1'b0}};
         step_r      <= {{(STEP_W-1){1'b0}}, 1'b1};
         pwm_load_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         tgt_ready_r <= 1'b1;
`ifdef DUTY_CLAMP_EN
         clamp_hit_r <= 1'b0;
`endif
      end else begin
         pwm_load_r <= 1'b0;
         done_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (tgt_valid && tgt_ready_r) begin
                  tgt_r       <= tgt_in_s;
                  step_r      <= step_in_s;
                  tgt_ready_r <= 1'b0;
`ifdef DUTY_CLAMP_EN
                  clamp_hit_r <= clamp_s;
`endif
                  if (tgt_in_s > duty_r) begin
                     state_r <= ST_RAMP_UP;
                     busy_r  <= 1'b1;
                  end else if (tgt_in_s < duty_r) begin
                     state_r <= ST_RAMP_DOWN;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end
               end
            end
            ST_RAMP_UP: begin
               if (abort) begin
                  state_r     <= ST_IDLE;
                  busy_r      <= 1'b0;
                  tgt_ready_r <= 1'b1;
               end else if (tick) begin
                  duty_r     <= up_next_s;
                  pwm_load_r <= 1'b1;
                  if (up_next_s == tgt_r) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end
            end
            ST_RAMP_DOWN: begin
               if (abort) begin
                  state_r     <= ST_IDLE;
                  busy_r      <= 1'b0;
                  tgt_ready_r <= 1'b1;
               end else if (tick) begin
                  duty_r     <= down_next_s;
                  pwm_load_r <= 1'b1;
                  if (down_next_s == tgt_r) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               tgt_ready_r <= 1'b1;
            end
            default: begin
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               tgt_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign duty      = duty_r;
   assign pwm_load  = pwm_load_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign tgt_ready = tgt_ready_r;
`ifdef DUTY_CLAMP_EN
   assign clamp_hit = clamp_hit_r;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a table of chained ramps plus hand sequences for
// accept-cycle tick, held request, abort, mid-ramp reset and the top-of-range/clamp cases.
module tb_pwm_ramp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [7:0] tgt_duty;
   logic [3:0] step;
   logic       abort;
   logic [7:0] duty;
   logic       pwm_load;
   logic       busy;
   logic       done;
`ifdef DUTY_CLAMP_EN
   logic       clamp_hit;
`endif

   int n_vec = 0;
   int n_err = 0;

   pwm_ramp_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .tgt_duty  (tgt_duty),
      .step      (step),
      .abort     (abort),
      .duty      (duty),
      .pwm_load  (pwm_load),
      .busy      (busy),
      .done      (done)
`ifdef DUTY_CLAMP_EN
      ,
      .clamp_hit (clamp_hit)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] tgt;
      logic [3:0] stp;
      int         per;
      logic [7:0] exp_first;
      logic [7:0] exp_final;
      int         exp_loads;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Accept one target, tick every 'per' clocks, and check the resulting ramp.
   task automatic run_ramp(input string nm, input logic [7:0] t, input logic [3:0] s,
                           input int per, input logic [7:0] exp_first,
                           input logic [7:0] exp_final, input int exp_loads);
      int         k;
      int         loads;
      int         dones;
      logic [7:0] first;
      logic       seen;
      loads = 0;
      dones = 0;
      first = 8'd0;
      seen  = 1'b0;
      k     = 0;
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_duty  = t;
      step      = s;
      tick      = 1'b0;
      @(negedge clk);
      tgt_valid = 1'b0;
      while (!seen && k < 600) begin
         if (pwm_load) begin
            if (loads == 0) first = duty;
            loads++;
         end
         if (done) begin
            dones++;
            seen = 1'b1;
         end else begin
            tick = ((k % per) == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            k++;
         end
      end
      tick = 1'b0;
      check({nm, "_timeout"}, {31'd0, seen}, 32'd1);
      check({nm, "_final"}, {24'd0, duty}, {24'd0, exp_final});
      check({nm, "_loads"}, loads, exp_loads);
      if (exp_loads > 0) check({nm, "_first"}, {24'd0, first}, {24'd0, exp_first});
      if (exp_loads == 0) check({nm, "_eq_lat"}, k, 32'd0);
      @(negedge clk);
      if (done) dones++;
      check({nm, "_dones"}, dones, 32'd1);
      check({nm, "_ready"}, {31'd0, tgt_ready}, 32'd1);
      check({nm, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'd10,  4'd3,  4, 8'd3,   8'd10,  4};
      vecs[1] = '{8'd0,   4'd4,  2, 8'd6,   8'd0,   3};
      vecs[2] = '{8'd5,   4'd0,  1, 8'd1,   8'd5,   5};
      vecs[3] = '{8'd5,   4'd7,  3, 8'd0,   8'd5,   0};
      vecs[4] = '{8'd200, 4'd15, 1, 8'd20,  8'd200, 13};
      vecs[5] = '{8'd190, 4'd9,  5, 8'd191, 8'd190, 2};

      rst       = 1'b1;
      tick      = 1'b0;
      tgt_valid = 1'b0;
      tgt_duty  = 8'd0;
      step      = 4'd0;
      abort     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_duty", {24'd0, duty}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_load", {31'd0, pwm_load}, 32'd0);
      check("rst_ready", {31'd0, tgt_ready}, 32'd1);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_ramp($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].stp, vecs[i].per,
                  vecs[i].exp_first, vecs[i].exp_final, vecs[i].exp_loads);
      end

      // Tick in accept cycle is ignored; held request is not accepted mid-ramp.
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_duty  = 8'd195;
      step      = 4'd2;
      tick      = 1'b1;
      @(negedge clk);
      check("acc_tick_duty", {24'd0, duty}, 32'd190);
      check("acc_tick_load", {31'd0, pwm_load}, 32'd0);
      check("acc_busy", {31'd0, busy}, 32'd1);
      check("acc_ready", {31'd0, tgt_ready}, 32'd0);
      tgt_duty = 8'd100;
      @(negedge clk);
      check("lat_duty", {24'd0, duty}, 32'd192);
      check("lat_load", {31'd0, pwm_load}, 32'd1);
      tick = 1'b0;
      @(negedge clk);
      check("notick_duty", {24'd0, duty}, 32'd192);
      check("notick_load", {31'd0, pwm_load}, 32'd0);
      tick = 1'b1;
      @(negedge clk);
      check("held_duty1", {24'd0, duty}, 32'd194);
      @(negedge clk);
      tick = 1'b0;
      check("held_duty2", {24'd0, duty}, 32'd195);
      check("held_done", {31'd0, done}, 32'd1);
      check("held_done_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("held_ready", {31'd0, tgt_ready}, 32'd1);
      check("held_done_once", {31'd0, done}, 32'd0);
      tgt_valid = 1'b0;
      @(negedge clk);
      check("held_not_taken", {31'd0, busy}, 32'd0);
      check("held_final", {24'd0, duty}, 32'd195);

      // Abort with a simultaneous tick holds duty at 6.
      do_reset();
      run_ramp("to6", 8'd6, 4'd6, 1, 8'd6, 8'd6, 1);
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_duty  = 8'd10;
      step      = 4'd1;
      @(negedge clk);
      tgt_valid = 1'b0;
      check("abort_pre_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      tick  = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tick  = 1'b0;
      check("abort_duty", {24'd0, duty}, 32'd6);
      check("abort_load", {31'd0, pwm_load}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_ready", {31'd0, tgt_ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);

      // Reset for two cycles in the middle of a ramp from duty 6.
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_duty  = 8'd20;
      step      = 4'd3;
      @(negedge clk);
      tgt_valid = 1'b0;
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst  = 1'b1;
      tick = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("midrst_duty%0d", c), {24'd0, duty}, 32'd0);
         check($sformatf("midrst_busy%0d", c), {31'd0, busy}, 32'd0);
         check($sformatf("midrst_ready%0d", c), {31'd0, tgt_ready}, 32'd1);
         check($sformatf("midrst_done%0d", c), {31'd0, done}, 32'd0);
      end
      rst  = 1'b0;
      tick = 1'b0;
      @(negedge clk);
      check("postrst_done", {31'd0, done}, 32'd0);
      check("postrst_duty", {24'd0, duty}, 32'd0);

`ifdef DUTY_CLAMP_EN
      run_ramp("clamp", 8'd250, 4'd15, 1, 8'd15, 8'd200, 14);
      check("clamp_hit", {31'd0, clamp_hit}, 32'd1);
      run_ramp("unclamp", 8'd100, 4'd15, 1, 8'd185, 8'd100, 7);
      check("clamp_clear", {31'd0, clamp_hit}, 32'd0);
`else
      run_ramp("to_fa", 8'hFA, 4'd15, 1, 8'd15, 8'hFA, 17);
      run_ramp("no_wrap", 8'hFF, 4'd15, 2, 8'hFF, 8'hFF, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
